// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and constants for the 4x4 keypad scanner.
//               Holds the scanner state type, the row/column to hex keymap,
//               the default timing constants and small row-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  // Timing at a 48 MHz system clock: 100 us per column, 20 ms debounce.
  localparam int DEFAULT_SCAN_DIV        = 4800;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 960000;

  // KEYMAP[row][col]
  localparam logic [3:0] KEYMAP [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // True when exactly one active-low row line is asserted.
  function automatic logic exactly_one_low(input logic [3:0] v);
    return ($countones(~v) == 1);
  endfunction

  // Index of the asserted (low) row; meaningful only when exactly one is low.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for asynchronous level inputs.
//               Resets to all-ones so idle pulled-up lines read inactive.
// Ports       : clk   - destination clock
//               reset - asynchronous, active-low reset
//               d     - asynchronous input bus
//               q     - synchronized output bus
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad scanner. Drives one active-low column at a
//               time, synchronizes the active-low rows, debounces press and
//               release, and emits one key_valid strobe per accepted press.
// Ports       : clk       - system clock
//               reset     - asynchronous, active-low reset
//               row       - raw keypad rows, active-low, asynchronous
//               col       - column drives, active-low, exactly one low
//               key_code  - hex value of last accepted key
//               key_valid - one-cycle strobe when key_code updates
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = DEFAULT_SCAN_DIV,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]         rs;
  state_t             state, state_next;
  logic [1:0]         col_idx, col_idx_next;
  logic [1:0]         row_sel, row_sel_next;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_next;
  logic [DB_W-1:0]    db_cnt, db_cnt_next;
  logic [3:0]         key_code_next;
  logic               key_valid_next;
  logic               row_hit;

  sync_2ff #(
    .WIDTH (4)
  ) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row),
    .q     (rs)
  );

  // Column drive decoded straight from the registered index, so reset forces
  // 4'b1110 without waiting for a clock edge.
  assign col = ~(4'b0001 << col_idx);

  // Latched row currently pulled low (active-low sense).
  assign row_hit = ~rs[row_sel];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_sel   <= 2'd0;
      dwell_cnt <= '0;
      db_cnt    <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_next;
      col_idx   <= col_idx_next;
      row_sel   <= row_sel_next;
      dwell_cnt <= dwell_cnt_next;
      db_cnt    <= db_cnt_next;
      key_code  <= key_code_next;
      key_valid <= key_valid_next;
    end
  end

  always_comb begin
    state_next     = state;
    col_idx_next   = col_idx;
    row_sel_next   = row_sel;
    dwell_cnt_next = dwell_cnt;
    db_cnt_next    = db_cnt;
    key_code_next  = key_code;
    key_valid_next = 1'b0;

    case (state)
      SCAN: begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_cnt_next = '0;
          if (exactly_one_low(rs)) begin
            // Column stays frozen on this index until the key is released.
            row_sel_next = low_index(rs);
            db_cnt_next  = '0;
            state_next   = DB_PRESS;
          end else begin
            col_idx_next = col_idx + 2'd1;
          end
        end else begin
          dwell_cnt_next = dwell_cnt + 1'b1;
        end
      end

      DB_PRESS: begin
        if (!row_hit) begin
          state_next     = SCAN;
          col_idx_next   = col_idx + 2'd1;
          dwell_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
          state_next     = HELD;
          key_code_next  = KEYMAP[row_sel][col_idx];
          key_valid_next = 1'b1;
        end else begin
          db_cnt_next = db_cnt + 1'b1;
        end
      end

      HELD: begin
        if (!row_hit) begin
          db_cnt_next = '0;
          state_next  = DB_RELEASE;
        end
      end

      DB_RELEASE: begin
        if (row_hit) begin
          // A bounce back to contact resumes the hold; it is never a new press.
          state_next = HELD;
        end else if (db_cnt == DB_LAST) begin
          state_next     = SCAN;
          col_idx_next   = col_idx + 2'd1;
          dwell_cnt_next = '0;
        end else begin
          db_cnt_next = db_cnt + 1'b1;
        end
      end

      default: begin
        state_next = SCAN;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner. A keypad model turns
//               the set of pressed keys into row levels from the column
//               drives; expected key codes are queued at press time and a
//               monitor pops them on every key_valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;

  // keys[r*4+c] = 1 when the switch at row r, column c is closed
  logic [15:0] keys;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] exp_q[$];
  logic       prev_valid;

  logic [3:0] keymap_tb [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A closed switch connects its row to its column; a row reads low when any
  // closed switch on it sits in the column currently driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if ($countones(~col) != 1) begin
        n_fail++;
        $display("FAIL col_onehot: col=%b, required exactly one low bit", col);
      end
      if (key_valid) begin
        n_cmp++;
        if (prev_valid) begin
          n_fail++;
          $display("FAIL valid_adjacent: key_valid high on two consecutive cycles, required single-cycle strobe");
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: key_code=%h, required no strobe", key_code);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (key_code !== e) begin
            n_fail++;
            $display("FAIL key_code: got %h, required %h", key_code, e);
          end
        end
      end
      prev_valid = key_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d strobes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_col(input logic [3:0] target, input int budget, output int waited);
    waited = 0;
    @(negedge clk);
    while (col !== target && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (col !== target) begin
      n_fail++;
      $display("FAIL col_wait: col=%b, required %b", col, target);
    end
  endtask

  initial begin
    int w;
    int lat;
    int start_idx;
    logic [3:0] exp_col;
    int k;

    keys  = 16'h0;
    rst_n = 1'b0;
    prev_valid = 1'b0;
    #12;
    check("reset_col", 32'(col), 32'(4'b1110));
    check("reset_key_code", 32'(key_code), 32'h0);
    check("reset_key_valid", 32'(key_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean press of "5": strobe 4 dwell + 8 debounce cycles after col1 appears.
    wait_col(4'b1110, 20, w);
    keys[5] = 1'b1;
    exp_q.push_back(4'h5);
    wait_col(4'b1101, 20, w);
    lat = 0;
    while (!key_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("press5_latency", 32'(lat), 32'd12);
    repeat (20) @(negedge clk);
    check("press5_col_frozen", 32'(col), 32'(4'b1101));
    keys[5] = 1'b0;
    repeat (30) @(negedge clk);
    wait_drain(1);

    // Reset in the middle of press debounce.
    keys[5] = 1'b1;
    wait_col(4'b1101, 20, w);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_col", 32'(col), 32'(4'b1110));
    check("async_reset_valid", 32'(key_valid), 32'h0);
    check("async_reset_code", 32'(key_code), 32'h0);
    keys[5] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("restart_col0", 32'(col), 32'(4'b1110));
    end
    @(negedge clk);
    check("restart_col1", 32'(col), 32'(4'b1101));

    // Bouncy press of "5".
    wait_col(4'b1101, 20, w);
    exp_q.push_back(4'h5);
    keys[5] = 1'b1;
    repeat (3) @(negedge clk);
    keys[5] = 1'b0;
    @(negedge clk);
    keys[5] = 1'b1;
    repeat (60) @(negedge clk);
    keys[5] = 1'b0;
    repeat (30) @(negedge clk);
    wait_drain(1);

    // Hold "A", add "3", release "A" with bounce; "3" follows.
    keys[3] = 1'b1;
    exp_q.push_back(4'hA);
    wait_drain(60);
    keys[2] = 1'b1;
    exp_q.push_back(4'h3);
    repeat (200) @(negedge clk);
    check("holdA_col_frozen", 32'(col), 32'(4'b0111));
    keys[3] = 1'b0;
    @(negedge clk);
    keys[3] = 1'b1;
    @(negedge clk);
    keys[3] = 1'b0;
    wait_drain(80);
    keys[2] = 1'b0;
    repeat (30) @(negedge clk);

    // Two rows low on column 0: no strobe, column keeps rotating.
    keys[4] = 1'b1;
    keys[8] = 1'b1;
    wait_col(4'b1110, 20, w);
    while (col === 4'b1110) @(negedge clk);
    start_idx = 1;
    for (int i = 0; i < 24; i++) begin
      exp_col = ~(4'b0001 << ((start_idx + i / 4) % 4));
      check("multi_rotate", 32'(col), 32'(exp_col));
      @(negedge clk);
    end
    keys[4] = 1'b0;
    keys[8] = 1'b0;
    repeat (10) @(negedge clk);

    // "D" then "0"; key_code holds D between them.
    keys[15] = 1'b1;
    exp_q.push_back(4'hD);
    wait_drain(60);
    repeat (10) @(negedge clk);
    keys[15] = 1'b0;
    repeat (30) @(negedge clk);
    check("hold_code_D", 32'(key_code), 32'hD);
    keys[13] = 1'b1;
    exp_q.push_back(4'h0);
    wait_drain(60);
    repeat (10) @(negedge clk);
    keys[13] = 1'b0;
    repeat (30) @(negedge clk);

    // Randomized single-key presses with optional bounce.
    for (int n = 0; n < 16; n++) begin
      k = $urandom_range(15);
      repeat ($urandom_range(7)) @(negedge clk);
      exp_q.push_back(keymap_tb[k]);
      if ($urandom_range(1) == 1) begin
        keys[k] = 1'b1;
        repeat ($urandom_range(3, 1)) @(negedge clk);
        keys[k] = 1'b0;
        repeat ($urandom_range(2, 1)) @(negedge clk);
      end
      keys[k] = 1'b1;
      repeat (50 + $urandom_range(30)) @(negedge clk);
      keys[k] = 1'b0;
      if ($urandom_range(1) == 1) begin
        repeat ($urandom_range(3, 1)) @(negedge clk);
        keys[k] = 1'b1;
        repeat ($urandom_range(3, 1)) @(negedge clk);
        keys[k] = 1'b0;
      end
      repeat (30) @(negedge clk);
      wait_drain(1);
    end

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
